board_io_adapter: RTL and testbench

BOARD_IO_ADAPTER -- requirements
Module: board_io_adapter

---
 rtl/board_io_adapter_if.sv | 33 +++
 rtl/board_io_adapter.sv | 119 +++++++++++
 tb/tb_board_io_adapter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_io_adapter_if.sv
// Bundles the board-side buttons and VGA pins with the design-side colour, sync and enable signals.
// The slave modport is the adapter's view; the master modport is the view of whatever drives it.
interface board_io_adapter_if #(
  parameter int NUM_BTN     = 4,
  parameter int COLOR_IN_W  = 2,
  parameter int COLOR_OUT_W = 4
);
  logic [NUM_BTN-1:0]     btn_raw;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_press;
  logic                   clk_en;
  logic [COLOR_IN_W-1:0]  red_in;
  logic [COLOR_IN_W-1:0]  green_in;
  logic [COLOR_IN_W-1:0]  blue_in;
  logic                   hsync_in;
  logic                   vsync_in;
  logic                   blank_in;
  logic [COLOR_OUT_W-1:0] vga_red;
  logic [COLOR_OUT_W-1:0] vga_green;
  logic [COLOR_OUT_W-1:0] vga_blue;
  logic                   hsync;
  logic                   vsync;

  modport slave (
    input  btn_raw, red_in, green_in, blue_in, hsync_in, vsync_in, blank_in,
    output btn_level, btn_press, clk_en, vga_red, vga_green, vga_blue, hsync, vsync
  );

  modport master (
    output btn_raw, red_in, green_in, blue_in, hsync_in, vsync_in, blank_in,
    input  btn_level, btn_press, clk_en, vga_red, vga_green, vga_blue, hsync, vsync
  );
endinterface

// File: rtl/board_io_adapter.sv
// Board I/O adapter: debounces the push-buttons, generates a divided clock enable,
// and expands and registers the design's colour and sync signals for the VGA DAC.
module board_io_adapter #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CLK_DIV         = 2,
  parameter int COLOR_IN_W      = 2,
  parameter int COLOR_OUT_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  board_io_adapter_if.slave  io
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SHIFT = COLOR_OUT_W - COLOR_IN_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [NUM_BTN-1:0] btnSync1_q, btnSync2_q;
  logic [NUM_BTN-1:0] btnLevel_q, btnLevel_d;
  logic [NUM_BTN-1:0] btnPress_q, btnPress_d;
  logic [CNT_W-1:0]   dbCnt_q [NUM_BTN];
  logic [CNT_W-1:0]   dbCnt_d [NUM_BTN];

  logic [DIV_W-1:0]   divCnt_q, divCnt_d;
  logic               clkEn_q, clkEn_d;

  logic [COLOR_OUT_W-1:0] vgaRed_q, vgaRed_d;
  logic [COLOR_OUT_W-1:0] vgaGreen_q, vgaGreen_d;
  logic [COLOR_OUT_W-1:0] vgaBlue_q, vgaBlue_d;
  logic                   hsync_q, vsync_q;

  // Full-scale input stays full-scale so white remains white on the wider DAC.
  function automatic logic [COLOR_OUT_W-1:0] expandColour(input logic [COLOR_IN_W-1:0] v);
    if (&v) begin
      return '1;
    end
    return COLOR_OUT_W'(v) << SHIFT;
  endfunction

  always_comb begin
    btnLevel_d = btnLevel_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      dbCnt_d[i] = '0;
      if (btnSync2_q[i] != btnLevel_q[i]) begin
        if (dbCnt_q[i] == CNT_LAST) begin
          btnLevel_d[i] = ~btnLevel_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + CNT_W'(1);
        end
      end
    end
    btnPress_d = btnLevel_d & ~btnLevel_q;
  end

  // clk_en is a registered copy of the terminal-count compare, so the first tick
  // after reset lands CLK_DIV edges in and reset itself never shows a tick.
  always_comb begin
    divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
    clkEn_d  = (divCnt_q == DIV_LAST);
  end

  always_comb begin
    vgaRed_d   = '0;
    vgaGreen_d = '0;
    vgaBlue_d  = '0;
    if (!io.blank_in) begin
      vgaRed_d   = expandColour(io.red_in);
      vgaGreen_d = expandColour(io.green_in);
      vgaBlue_d  = expandColour(io.blue_in);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btnSync1_q <= '0;
      btnSync2_q <= '0;
      btnLevel_q <= '0;
      btnPress_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dbCnt_q[i] <= '0;
      end
      divCnt_q   <= '0;
      clkEn_q    <= 1'b0;
      vgaRed_q   <= '0;
      vgaGreen_q <= '0;
      vgaBlue_q  <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      btnSync1_q <= io.btn_raw;
      btnSync2_q <= btnSync1_q;
      btnLevel_q <= btnLevel_d;
      btnPress_q <= btnPress_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
      divCnt_q   <= divCnt_d;
      clkEn_q    <= clkEn_d;
      vgaRed_q   <= vgaRed_d;
      vgaGreen_q <= vgaGreen_d;
      vgaBlue_q  <= vgaBlue_d;
      hsync_q    <= io.hsync_in;
      vsync_q    <= io.vsync_in;
    end
  end

  assign io.btn_level = btnLevel_q;
  assign io.btn_press = btnPress_q;
  assign io.clk_en    = clkEn_q;
  assign io.vga_red   = vgaRed_q;
  assign io.vga_green = vgaGreen_q;
  assign io.vga_blue  = vgaBlue_q;
  assign io.hsync     = hsync_q;
  assign io.vsync     = vsync_q;

endmodule

// File: tb/tb_board_io_adapter.sv
// Self-checking bench for board_io_adapter: defaults, a CLK_DIV=3 copy, and a
// CLK_DIV=1 copy with equal colour widths, sharing one clock and reset.
module tb_board_io_adapter;

  logic clock;
  logic reset;

  board_io_adapter_if #(.NUM_BTN(4), .COLOR_IN_W(2), .COLOR_OUT_W(4)) busA ();
  board_io_adapter_if #(.NUM_BTN(4), .COLOR_IN_W(2), .COLOR_OUT_W(4)) busB ();
  board_io_adapter_if #(.NUM_BTN(4), .COLOR_IN_W(2), .COLOR_OUT_W(2)) busC ();

  board_io_adapter #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .CLK_DIV(2), .COLOR_IN_W(2), .COLOR_OUT_W(4))
    dut (.clock(clock), .reset(reset), .io(busA));
  board_io_adapter #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .CLK_DIV(3), .COLOR_IN_W(2), .COLOR_OUT_W(4))
    dutDiv3 (.clock(clock), .reset(reset), .io(busB));
  board_io_adapter #(.NUM_BTN(4), .DEBOUNCE_CYCLES(4), .CLK_DIV(1), .COLOR_IN_W(2), .COLOR_OUT_W(2))
    dutDiv1 (.clock(clock), .reset(reset), .io(busC));

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic [1:0] nr;
    logic [1:0] ng;
    logic [1:0] nb;
  } vidExp_t;

  vidExp_t expQ[$];
  logic [3:0] expandTbl [4];
  int checkCount;
  int passCount;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic driveVideo(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                            input logic hs, input logic vs, input logic blank);
    busA.red_in = r; busA.green_in = g; busA.blue_in = b;
    busA.hsync_in = hs; busA.vsync_in = vs; busA.blank_in = blank;
    busC.red_in = r; busC.green_in = g; busC.blue_in = b;
    busC.hsync_in = hs; busC.vsync_in = vs; busC.blank_in = blank;
  endtask

  task automatic test_reset();
    driveVideo(2'd3, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkCount++;
    if ({busA.btn_level, busA.btn_press} !== 8'h00)
      $display("[TB] FAIL reset_btn: got %b expected 00000000", {busA.btn_level, busA.btn_press});
    else passCount++;
    checkCount++;
    if ({busA.vga_red, busA.vga_green, busA.vga_blue} !== 12'h000)
      $display("[TB] FAIL reset_vga: got %h expected 000", {busA.vga_red, busA.vga_green, busA.vga_blue});
    else passCount++;
    checkCount++;
    if ({busA.hsync, busA.vsync} !== 2'b00)
      $display("[TB] FAIL reset_sync: got %b expected 00", {busA.hsync, busA.vsync});
    else passCount++;
    checkCount++;
    if ({busA.clk_en, busB.clk_en, busC.clk_en} !== 3'b000)
      $display("[TB] FAIL reset_clk_en: got %b expected 000", {busA.clk_en, busB.clk_en, busC.clk_en});
    else passCount++;
  endtask

  task automatic test_clk_en();
    logic expA, expB;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      expA = (k % 2 == 0);
      expB = (k % 3 == 0);
      checkCount++;
      if (busA.clk_en !== expA)
        $display("[TB] FAIL clk_en_div2 edge %0d: got %b expected %b", k, busA.clk_en, expA);
      else passCount++;
      checkCount++;
      if (busB.clk_en !== expB)
        $display("[TB] FAIL clk_en_div3 edge %0d: got %b expected %b", k, busB.clk_en, expB);
      else passCount++;
      checkCount++;
      if (busC.clk_en !== 1'b1)
        $display("[TB] FAIL clk_en_div1 edge %0d: got %b expected 1", k, busC.clk_en);
      else passCount++;
    end
  endtask

  task automatic test_debounce();
    logic expLevel, expPress;
    busA.btn_raw = 4'b0000;
    repeat (8) tick();
    busA.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      expLevel = (k >= 6);
      expPress = (k == 6);
      checkCount++;
      if ({busA.btn_level[0], busA.btn_press[0]} !== {expLevel, expPress})
        $display("[TB] FAIL debounce_rise edge %0d: level/press got %b%b expected %b%b",
                 k, busA.btn_level[0], busA.btn_press[0], expLevel, expPress);
      else passCount++;
    end
    busA.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expLevel = (k < 6);
      checkCount++;
      if ({busA.btn_level[0], busA.btn_press[0]} !== {expLevel, 1'b0})
        $display("[TB] FAIL debounce_fall edge %0d: level/press got %b%b expected %b0",
                 k, busA.btn_level[0], busA.btn_press[0], expLevel);
      else passCount++;
    end
  endtask

  task automatic test_glitch();
    busA.btn_raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) busA.btn_raw[1] = 1'b0;
      tick();
      checkCount++;
      if ({busA.btn_level[1], busA.btn_press[1]} !== 2'b00)
        $display("[TB] FAIL glitch edge %0d: level/press got %b%b expected 00",
                 k, busA.btn_level[1], busA.btn_press[1]);
      else passCount++;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] expLevel, expPress;
    busA.btn_raw = 4'b1001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expLevel = (k >= 6) ? 4'b1001 : 4'b0000;
      expPress = (k == 6) ? 4'b1001 : 4'b0000;
      checkCount++;
      if ({busA.btn_level, busA.btn_press} !== {expLevel, expPress})
        $display("[TB] FAIL simultaneous edge %0d: level %b press %b expected level %b press %b",
                 k, busA.btn_level, busA.btn_press, expLevel, expPress);
      else passCount++;
    end
    busA.btn_raw = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_debounce();
    logic expLevel, expPress;
    busA.btn_raw[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkCount++;
      if (busA.btn_press !== 4'b0000)
        $display("[TB] FAIL mid_debounce_pre edge %0d: press got %b expected 0000", k, busA.btn_press);
      else passCount++;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expLevel = (k >= 6);
      expPress = (k == 6);
      checkCount++;
      if ({busA.btn_level[2], busA.btn_press[2]} !== {expLevel, expPress})
        $display("[TB] FAIL mid_debounce_post edge %0d: level/press got %b%b expected %b%b",
                 k, busA.btn_level[2], busA.btn_press[2], expLevel, expPress);
      else passCount++;
    end
    busA.btn_raw[2] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_colour();
    vidExp_t e;
    vidExp_t got;
    logic [1:0] r, g, b;
    logic hs, vs, blank;
    driveVideo(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        r = 2'(i);
        g = 2'(i + 1);
        b = 2'(i + 3);
        hs = r[0];
        vs = r[1];
        blank = (pass == 1);
        driveVideo(r, g, b, hs, vs, blank);
        e.r  = blank ? 4'h0 : expandTbl[r];
        e.g  = blank ? 4'h0 : expandTbl[g];
        e.b  = blank ? 4'h0 : expandTbl[b];
        e.hs = hs;
        e.vs = vs;
        e.nr = blank ? 2'b00 : r;
        e.ng = blank ? 2'b00 : g;
        e.nb = blank ? 2'b00 : b;
        expQ.push_back(e);
        tick();
        got.r = busA.vga_red; got.g = busA.vga_green; got.b = busA.vga_blue;
        e = expQ.pop_front();
        checkCount++;
        if ({got.r, got.g, got.b} !== {e.r, e.g, e.b})
          $display("[TB] FAIL colour pass %0d idx %0d: got %h expected %h",
                   pass, i, {got.r, got.g, got.b}, {e.r, e.g, e.b});
        else passCount++;
        checkCount++;
        if ({busA.hsync, busA.vsync} !== {e.hs, e.vs})
          $display("[TB] FAIL sync pass %0d idx %0d: got %b expected %b",
                   pass, i, {busA.hsync, busA.vsync}, {e.hs, e.vs});
        else passCount++;
        checkCount++;
        if ({busC.vga_red, busC.vga_green, busC.vga_blue} !== {e.nr, e.ng, e.nb})
          $display("[TB] FAIL colour_equal_width pass %0d idx %0d: got %b expected %b",
                   pass, i, {busC.vga_red, busC.vga_green, busC.vga_blue}, {e.nr, e.ng, e.nb});
        else passCount++;
      end
    end
    driveVideo(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    expandTbl[0] = 4'b0000;
    expandTbl[1] = 4'b0100;
    expandTbl[2] = 4'b1000;
    expandTbl[3] = 4'b1111;
    reset = 1'b1;
    busA.btn_raw = 4'b0000;
    busB.btn_raw = 4'b0000;
    busC.btn_raw = 4'b0000;
    busB.red_in = 2'd0; busB.green_in = 2'd0; busB.blue_in = 2'd0;
    busB.hsync_in = 1'b0; busB.vsync_in = 1'b0; busB.blank_in = 1'b0;
    driveVideo(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_clk_en();
    test_debounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_colour();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
